// File: rtl/vec_add_seq.sv
// Element-wise add sequencer: reads A/B at a shared address, writes A+B to the result memory.
// Build option VEC_ADD_SAT_EN: saturate the written sum instead of wrapping on carry-out.
module vec_add_seq #(
    parameter int unsigned AW     = 6,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] len_m1,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] a_data,
    input  logic [DW-1:0] b_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [AW-1:0] len_q, len_nxt;
    logic          busy_nxt, done_nxt, ovf_nxt, rd_en_nxt, wr_en_nxt;
    logic [AW-1:0] rd_addr_nxt, wr_addr_nxt;
    logic [DW-1:0] wr_data_nxt;
    logic [DW:0]   sum_c;

    // Read-latency pipeline: one (valid, addr) entry per issued read.
    logic [RD_LAT-1:0]         pipe_vld;
    logic [RD_LAT-1:0][AW-1:0] pipe_addr;

    assign sum_c = {1'b0, a_data} + {1'b0, b_data};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            pipe_vld  <= '0;
            pipe_addr <= '0;
        end else begin
            len_q   <= len_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            ovf     <= ovf_nxt;
            rd_en   <= rd_en_nxt;
            rd_addr <= rd_addr_nxt;
            wr_en   <= wr_en_nxt;
            wr_addr <= wr_addr_nxt;
            wr_data <= wr_data_nxt;
            // Entry enters alongside the read it tracks; exits as the registered write.
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
            pipe_vld[0]  <= rd_en_nxt;
            pipe_addr[0] <= rd_addr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        ovf_nxt     = ovf;
        rd_en_nxt   = 1'b0;
        rd_addr_nxt = rd_addr;
        wr_en_nxt   = pipe_vld[RD_LAT-1];
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;

        if (pipe_vld[RD_LAT-1]) begin
            wr_addr_nxt = pipe_addr[RD_LAT-1];
`ifdef VEC_ADD_SAT_EN
            wr_data_nxt = sum_c[DW] ? {DW{1'b1}} : sum_c[DW-1:0];
`else
            wr_data_nxt = sum_c[DW-1:0];
`endif
            ovf_nxt     = ovf | sum_c[DW];
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = READ;
                    len_nxt     = len_m1;
                    busy_nxt    = 1'b1;
                    ovf_nxt     = 1'b0;
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = '0;
                end
            end
            READ: begin
                // Compare against the latched length so a full sweep never wraps early.
                if (rd_addr == len_q) begin
                    state_nxt = DRAIN;
                end else begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = rd_addr + AW'(1);
                end
            end
            DRAIN: begin
                if (pipe_vld == '0) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
